// File: rtl/lsu.sv
// Load-store unit: one req/gnt/rvalid data-bus transaction per accepted load or store.
// Optional LSU_BUS_ERR_EN adds data_err_i / lsu_err_bus_o for erroring bus responses.
//   state | meaning
//   IDLE  | no transaction; sampling lsu_req_i
//   REQ   | data_req_o high, waiting for data_gnt_i
//   WAIT  | granted, waiting for data_rvalid_i
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
`ifdef LSU_BUS_ERR_EN
  input  logic                  data_err_i,
  output logic                  lsu_err_bus_o,
`endif
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  we_q, sign_ext_q;
  logic [1:0]            type_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  rvalid_q, err_mis_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  misaligned, accept, reject, done, resp_err;
  logic [BE_WIDTH-1:0]   be_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_ext;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  always_comb begin
    misaligned = 1'b0;
    be_d       = '0;
    wdata_d    = lsu_wdata_i;
    case (lsu_type_i)
      2'b00: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = lsu_addr_i[0];
        be_d       = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d    = {2{lsu_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned = lsu_addr_i[1:0] != 2'b00;
        be_d       = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state_q == IDLE) && lsu_req_i && !misaligned;
  assign reject = (state_q == IDLE) && lsu_req_i && misaligned;
  assign done   = (state_q == WAIT) && data_rvalid_i;

`ifdef LSU_BUS_ERR_EN
  assign resp_err = data_err_i;
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (data_gnt_i) state_d = WAIT;
      WAIT:    if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane selection uses the latched offset, not the live address.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = data_rdata_i[7:0];
      2'd1:    lane_b = data_rdata_i[15:8];
      2'd2:    lane_b = data_rdata_i[23:16];
      default: lane_b = data_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (type_q)
      2'b00:   rdata_ext = {{(DATA_WIDTH-8){sign_ext_q & lane_b[7]}}, lane_b};
      2'b01:   rdata_ext = {{(DATA_WIDTH-16){sign_ext_q & lane_h[15]}}, lane_h};
      default: rdata_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      type_q     <= 2'b00;
      be_q       <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_mis_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= done && !resp_err;
      rdata_q   <= (done && !we_q && !resp_err) ? rdata_ext : '0;
      err_mis_q <= reject;
      if (accept) begin
        addr_q     <= lsu_addr_i;
        wdata_q    <= wdata_d;
        we_q       <= lsu_we_i;
        sign_ext_q <= lsu_sign_ext_i;
        type_q     <= lsu_type_i;
        be_q       <= be_d;
      end
    end
  end

`ifdef LSU_BUS_ERR_EN
  logic err_bus_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_bus_q <= 1'b0;
    else       err_bus_q <= done && resp_err;
  end
  assign lsu_err_bus_o = err_bus_q;
`endif

  // Bus outputs are driven only in REQ so they read as zero everywhere else.
  assign lsu_busy_o           = state_q != IDLE;
  assign lsu_rvalid_o         = rvalid_q;
  assign lsu_rdata_o          = rdata_q;
  assign lsu_err_misaligned_o = err_mis_q;
  assign data_req_o           = state_q == REQ;
  assign data_addr_o          = data_req_o ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign data_we_o            = data_req_o & we_q;
  assign data_be_o            = data_req_o ? be_q : '0;
  assign data_wdata_o         = data_req_o ? wdata_q : '0;

endmodule
